// File: rtl/hs_sync_rx_pkg.sv
// Shared definitions for the 4-phase req/ack handshake crossing.
// The future source side (hs_sync_tx) imports the same state encoding.
package hs_sync_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } hs_state_t;

endpackage

// File: rtl/hs_sync_rx_sync_bit.sv
// Plain N-flop level synchronizer with synchronous active-low reset to 0.
// Used for req here and for ack on the source side.
module sync_bit #(
  parameter int SYNC_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_LEN-1:0] sync_q;
  logic [SYNC_LEN-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_LEN-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_LEN-1];

endmodule

// File: rtl/hs_sync_rx.sv
// Destination-side responder of a 4-phase req/ack crossing: synchronizes req,
// captures the source word and offers it as a valid/ready beat, then returns ack.
module hs_sync_rx
  import hs_sync_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SYNC_LEN   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_async,
  input  logic [DATA_WIDTH-1:0] data_async,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  logic                  req_s;
  hs_state_t             state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  sync_bit #(.SYNC_LEN(SYNC_LEN)) u_req_sync (
    .clk  (clk),
    .reset(reset),
    .d    (req_async),
    .q    (req_s)
  );

  // data_async is only sampled on IDLE->HOLD; the source holds it stable
  // for at least SYNC_LEN edges before req_s can be seen high.
  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          out_data_d  = data_async;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          ack_d       = 1'b1;
          state_d     = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ack_d       = 1'b0;
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign ack       = ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hs_sync_rx.sv
// Directed bench for hs_sync_rx: a per-edge vector table plus hand-written
// sequences for backpressure, back-to-back transfers and reset mid-transfer.
module tb_hs_sync_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_async;
  logic [7:0] data_async;
  logic       ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hs_sync_rx #(.DATA_WIDTH(8), .SYNC_LEN(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_async (req_async),
    .data_async(data_async),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  typedef struct {
    logic       rst_n;
    logic       req;
    logic [7:0] data;
    logic       rdy;
    logic       e_ack;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_busy;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  function automatic vec_t mk(logic r, logic q, logic [7:0] d, logic y,
                              logic ea, logic ev, logic [7:0] ed, logic eb);
    vec_t v;
    v.rst_n = r; v.req = q; v.data = d; v.rdy = y;
    v.e_ack = ea; v.e_valid = ev; v.e_data = ed; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs sampled the same way.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] src_ack_sync;
  int         src_st;
  int         src_idx;
  logic [7:0] beats[$];
  int         k;
  bit         seen;

  initial begin
    reset = 1'b0; req_async = 1'b0; data_async = 8'h00; out_ready = 1'b0;

    // Reset with req high, basic transfer, ready-while-idle, data skew while req low.
    vecs[0]  = mk(0, 1, 8'h00, 0, 0, 0, 8'h00, 0);
    vecs[1]  = mk(0, 1, 8'h00, 0, 0, 0, 8'h00, 0);
    vecs[2]  = mk(0, 1, 8'h00, 0, 0, 0, 8'h00, 0);
    vecs[3]  = mk(1, 0, 8'hA5, 0, 0, 0, 8'h00, 0);
    vecs[4]  = mk(1, 1, 8'hA5, 0, 0, 0, 8'h00, 0);
    vecs[5]  = mk(1, 1, 8'hA5, 0, 0, 0, 8'h00, 0);
    vecs[6]  = mk(1, 1, 8'hA5, 0, 0, 1, 8'hA5, 1);
    vecs[7]  = mk(1, 1, 8'hA5, 0, 0, 1, 8'hA5, 1);
    vecs[8]  = mk(1, 1, 8'hA5, 1, 1, 0, 8'hA5, 1);
    vecs[9]  = mk(1, 0, 8'hA5, 1, 1, 0, 8'hA5, 1);
    vecs[10] = mk(1, 0, 8'hA5, 1, 1, 0, 8'hA5, 1);
    vecs[11] = mk(1, 0, 8'hA5, 1, 0, 0, 8'hA5, 0);
    vecs[12] = mk(1, 0, 8'h11, 1, 0, 0, 8'hA5, 0);
    vecs[13] = mk(1, 0, 8'h22, 1, 0, 0, 8'hA5, 0);
    vecs[14] = mk(1, 1, 8'h33, 0, 0, 0, 8'hA5, 0);
    vecs[15] = mk(1, 1, 8'h33, 0, 0, 0, 8'hA5, 0);
    vecs[16] = mk(1, 1, 8'h33, 0, 0, 1, 8'h33, 1);
    vecs[17] = mk(1, 1, 8'h33, 1, 1, 0, 8'h33, 1);
    vecs[18] = mk(1, 0, 8'h33, 0, 1, 0, 8'h33, 1);
    vecs[19] = mk(1, 0, 8'h33, 0, 1, 0, 8'h33, 1);
    vecs[20] = mk(1, 0, 8'h33, 0, 0, 0, 8'h33, 0);

    #1;
    for (int i = 0; i < NV; i++) begin
      reset = vecs[i].rst_n; req_async = vecs[i].req;
      data_async = vecs[i].data; out_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_ack", i),   ack,       vecs[i].e_ack);
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d_data", i),  out_data,  vecs[i].e_data);
      chk($sformatf("vec%0d_busy", i),  busy,      vecs[i].e_busy);
    end

    // Backpressure: beat must sit unchanged with ack low while ready is low.
    out_ready = 1'b0; data_async = 8'hC3; req_async = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      seen = out_valid;
    end
    chk("bp_valid_arrives", seen, 1'b1);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("bp_hold", {ack, out_valid, out_data}, {1'b0, 1'b1, 8'hC3});
    end
    out_ready = 1'b1;
    step();
    chk("bp_ack_rise", {ack, out_valid}, 2'b10);
    req_async = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 10 && busy; c++) step();
    chk("bp_return_idle", {busy, ack}, 2'b00);

    // Back-to-back: source reacts to ack through its own 2-flop sync.
    out_ready = 1'b1; src_ack_sync = 2'b00; src_st = 0; src_idx = 0;
    for (int c = 0; c < 300 && !(src_idx == 4 && src_st == 0 && !busy); c++) begin
      step();
      if (out_valid) beats.push_back(out_data);
      src_ack_sync = {src_ack_sync[0], ack};
      if (src_st == 0) begin
        if (src_idx < 4 && !src_ack_sync[1]) begin
          data_async = 8'(src_idx + 1);
          req_async  = 1'b1;
          src_st     = 1;
        end
      end else if (src_ack_sync[1]) begin
        req_async = 1'b0;
        src_idx++;
        src_st = 0;
      end
    end
    chk("b2b_words_sent", src_idx, 4);
    chk("b2b_beat_count", beats.size(), 4);
    for (int i = 0; i < 4 && i < beats.size(); i++)
      chk($sformatf("b2b_beat%0d", i), beats[i], 8'(i + 1));

    // Reset while in HOLD, then req still high yields a fresh beat.
    out_ready = 1'b0; data_async = 8'h5A; req_async = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      seen = out_valid;
    end
    chk("rst_mid_hold_reached", seen, 1'b1);
    reset = 1'b0;
    step();
    chk("rst_mid_cleared", {ack, out_valid, busy}, 3'b000);
    reset = 1'b1;
    for (k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("rst_mid_after%0d_valid", k), out_valid, (k == 3) ? 1'b1 : 1'b0);
    end
    chk("rst_mid_data", out_data, 8'h5A);
    out_ready = 1'b1;
    step();
    chk("rst_mid_ack", ack, 1'b1);
    req_async = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 10 && busy; c++) step();
    chk("rst_mid_idle", {busy, ack}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
